simd_issue_sched: RTL and testbench
===================================

SIMD_ISSUE_SCHED -- requirements
Module: simd_issue_sched

Interface
REQ-001 Parameter: QDEPTH, 4, command queue depth in entries (power of 2, >=2).
REQ-002 Parameter: AW, 6, RAM address width.
REQ-003 Parameter: OPW, 3, opcode width.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: cmd_valid  in  1  host command offer.
REQ-007 Port: cmd_ready  out  1  queue can accept; high when queue not full.
REQ-008 Port: cmd_opcode  in  OPW  ALU opcode for the command.
REQ-009 Port: cmd_base  in  AW  first RAM address of the operand vectors.
REQ-010 Port: cmd_len  in  AW  number of 128-bit vectors to process.
REQ-011 Port: flush  in  1  synchronous abort of queue and active command.
REQ-012 Port: mem_addr  out  AW  RAM read address, driven to both operand ports.
REQ-013 Port: mem_rd  out  1  RAM read strobe.
REQ-014 Port: procc_instruction  out  OPW  opcode broadcast to the four ALU lanes.
REQ-015 Port: procc_start  out  1  one-cycle start pulse to the lanes.
REQ-016 Port: procc_done  in  1  AND of all lane done flags.
REQ-017 Port: res_valid  out  1  one-cycle pulse; lane results for res_index are valid.
REQ-018 Port: res_index  out  AW  vector index (0..len-1) of the current result.
REQ-019 Port: cmd_done  out  1  one-cycle pulse on command retirement.
REQ-020 Port: busy  out  1  high whenever state is not IDLE.
REQ-021 Port: q_count  out  log2(QDEPTH)+1  queued (not yet fetched) commands.

Function
REQ-022 Queue: FIFO of {opcode, base, len}; push on cmd_valid & cmd_ready; cmd_ready = (q_count < QDEPTH), registered, so no push at full even if a pop occurs the same cycle.
REQ-023 Simultaneous push and pop when not full: q_count unchanged, both take effect.
REQ-024 FSM states: IDLE, FETCH, READ, START, WAIT, NEXT, DONE.
REQ-025 IDLE -> FETCH when q_count != 0; otherwise stay.
REQ-026 FETCH (1 cycle): pop head into op/base/len registers, idx <= 0; -> DONE if len == 0, else -> READ.
REQ-027 READ (1 cycle): mem_addr = (base + idx) mod 2^AW, mem_rd = 1; -> START.
REQ-028 START (1 cycle): procc_start = 1, procc_instruction = latched opcode; -> WAIT.
REQ-029 WAIT: hold mem_addr and procc_instruction; -> NEXT on procc_done = 1; no timeout.
REQ-030 NEXT (1 cycle): res_valid = 1, res_index = idx; if idx == len-1 -> DONE, else idx <= idx+1 and -> READ.
REQ-031 DONE (1 cycle): cmd_done = 1; -> FETCH if q_count != 0, else IDLE.
REQ-032 procc_done outside WAIT is ignored.
REQ-033 Address wraps modulo 2^AW (base 62, len 4 reads 62, 63, 0, 1).
REQ-034 procc_instruction holds its last value outside START/WAIT; mem_addr holds its last value when mem_rd = 0.
REQ-035 flush (any state, priority over all transitions): queue emptied, q_count <= 0, state <= IDLE; no cmd_done or res_valid pulse that cycle; a push offered in the flush cycle is dropped.

Reset
REQ-036 On reset low, asynchronously: state IDLE, queue empty, q_count 0, cmd_ready 1, mem_addr 0, mem_rd 0, procc_instruction 0, procc_start 0, res_valid 0, res_index 0, cmd_done 0, busy 0.
REQ-037 Reset mid-command discards all queued and active commands with no completion pulses; operation resumes on the first edge after reset release.

Verification
REQ-038 Single command op=3, base=5, len=2, procc_done 2 cycles after each start -> mem_addr 5 then 6; two procc_start and two res_valid pulses (index 0, 1); one cmd_done; busy low after DONE.
REQ-039 Push 5 commands back-to-back with the engine stalled in WAIT (QDEPTH=4) -> cmd_ready low after 4th queued entry; 5th held until a FETCH pop; all 5 retire in order.
REQ-040 base=62, len=4 -> mem_addr sequence 62, 63, 0, 1.
REQ-041 len=0 -> FETCH then DONE; cmd_done pulse; zero procc_start and res_valid pulses.
REQ-042 flush asserted in WAIT with 2 queued -> next cycle IDLE, q_count 0, busy 0, no cmd_done; later procc_done ignored.
REQ-043 reset pulled low in NEXT -> all outputs immediately at REQ-036 values; a new command after release runs normally from index 0.

Source files
------------

// File: rtl/simd_issue_sched.sv
// ---------------------------------------------------------------------------------------------
// simd_issue_sched
//   Command queue plus issue sequencer for a four-lane 128-bit SIMD ALU. The host pushes
//   {opcode, base, len} commands into a small FIFO. The sequencer takes one command at a time
//   and steps through its len vectors. For each vector it reads the RAM, starts the lanes,
//   waits for the lanes to finish and then publishes the result index.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  host command handshake; cmd_ready is registered (queue not full)
//   cmd_opcode/base/len  command payload
//   flush                synchronous abort of the queue and of the active command
//   mem_addr, mem_rd     RAM read address (held while mem_rd is low) and read strobe
//   procc_instruction    opcode broadcast to the lanes (held outside START/WAIT)
//   procc_start          one-cycle lane start pulse
//   procc_done           AND of the lane done flags; sampled only in WAIT
//   res_valid, res_index result strobe and the vector index it belongs to
//   cmd_done             one-cycle pulse when a command retires
//   busy, q_count        sequencer not idle; number of queued, not yet fetched commands
// ---------------------------------------------------------------------------------------------
module simd_issue_sched #(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned AW     = 6,
   parameter int unsigned OPW    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [OPW-1:0]            cmd_opcode,
   input  logic [AW-1:0]             cmd_base,
   input  logic [AW-1:0]             cmd_len,
   input  logic                      flush,
   output logic [AW-1:0]             mem_addr,
   output logic                      mem_rd,
   output logic [OPW-1:0]            procc_instruction,
   output logic                      procc_start,
   input  logic                      procc_done,
   output logic                      res_valid,
   output logic [AW-1:0]             res_index,
   output logic                      cmd_done,
   output logic                      busy,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam int unsigned QW = $clog2(QDEPTH);
   localparam int unsigned CW = QW + 1;
   localparam logic [CW-1:0] QFull = CW'(QDEPTH);

   typedef enum logic [2:0] {StIdle, StFetch, StRead, StStart, StWait, StNext, StDone} state_e;

   state_e r_state;
   state_e w_state_nxt;

   // Command FIFO
   logic [OPW-1:0] r_q_op   [QDEPTH];
   logic [AW-1:0]  r_q_base [QDEPTH];
   logic [AW-1:0]  r_q_len  [QDEPTH];
   logic [QW-1:0]  r_wptr;
   logic [QW-1:0]  r_rptr;
   logic [CW-1:0]  r_q_count;
   logic [CW-1:0]  w_cnt_nxt;
   logic           r_cmd_ready;
   logic           w_push;
   logic           w_pop;

   // Active command
   logic [OPW-1:0] r_op;
   logic [AW-1:0]  r_base;
   logic [AW-1:0]  r_len;
   logic [AW-1:0]  r_idx;
   logic [AW-1:0]  r_addr_hold;
   logic [OPW-1:0] r_instr_hold;
   logic [AW-1:0]  w_addr;
   logic           w_last;

   assign w_push = cmd_valid & r_cmd_ready & ~flush;
   // FETCH is entered only with a non-empty queue, so the pop never underflows.
   assign w_pop  = (r_state == StFetch) & ~flush;
   assign w_addr = r_base + r_idx;              // wraps modulo 2^AW by width
   assign w_last = (r_idx == (r_len - AW'(1)));

   // ------------------------------------------------------------------------------------------
   // Queue
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt = r_q_count;
      if (flush) begin
         w_cnt_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_cnt_nxt = r_q_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_q_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_op[r_wptr]   <= cmd_opcode;
         r_q_base[r_wptr] <= cmd_base;
         r_q_len[r_wptr]  <= cmd_len;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_q_count   <= '0;
         r_cmd_ready <= 1'b1;
      end else begin
         if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + QW'(1);
            if (w_pop)  r_rptr <= r_rptr + QW'(1);
         end
         r_q_count   <= w_cnt_nxt;
         // Registered full flag: a pop in the same cycle does not open a slot early.
         r_cmd_ready <= (w_cnt_nxt < QFull);
      end
   end

   // ------------------------------------------------------------------------------------------
   // Sequencer FSM: state register
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= StIdle;
      else        r_state <= w_state_nxt;
   end

   // Next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (r_q_count != '0) w_state_nxt = StFetch;
         StFetch: w_state_nxt = (r_q_len[r_rptr] == '0) ? StDone : StRead;
         StRead:  w_state_nxt = StStart;
         StStart: w_state_nxt = StWait;
         StWait:  if (procc_done) w_state_nxt = StNext;
         StNext:  w_state_nxt = w_last ? StDone : StRead;
         StDone:  w_state_nxt = (r_q_count != '0) ? StFetch : StIdle;
         default: w_state_nxt = StIdle;
      endcase
      if (flush) w_state_nxt = StIdle;
   end

   // Outputs
   always_comb begin
      mem_rd            = (r_state == StRead);
      mem_addr          = mem_rd ? w_addr : r_addr_hold;
      procc_start       = (r_state == StStart);
      procc_instruction = procc_start ? r_op : r_instr_hold;
      res_valid         = (r_state == StNext) & ~flush;
      res_index         = r_idx;
      cmd_done          = (r_state == StDone) & ~flush;
      busy              = (r_state != StIdle);
      q_count           = r_q_count;
      cmd_ready         = r_cmd_ready;
   end

   // ------------------------------------------------------------------------------------------
   // Active command registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op         <= '0;
         r_base       <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_addr_hold  <= '0;
         r_instr_hold <= '0;
      end else begin
         // The hold registers track whatever was actually driven, so the outputs never step
         // back to an older value after a flushed READ or START.
         if (r_state == StRead)  r_addr_hold  <= w_addr;
         if (r_state == StStart) r_instr_hold <= r_op;
         if (!flush) begin
            if (r_state == StFetch) begin
               r_op   <= r_q_op[r_rptr];
               r_base <= r_q_base[r_rptr];
               r_len  <= r_q_len[r_rptr];
               r_idx  <= '0;
            end
            if (r_state == StNext && !w_last) r_idx <= r_idx + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_simd_issue_sched.sv
// ---------------------------------------------------------------------------------------------
// tb_simd_issue_sched
//   Scoreboard bench. Each accepted command queues one expected entry per vector
//   {opcode, address, index} and one expected vector count. A monitor checks every read,
//   start, result and completion pulse against the fronts of those queues. A responder
//   returns procc_done a few cycles after each start, and can be stalled.
// ---------------------------------------------------------------------------------------------
module tb_simd_issue_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_opcode = '0;
   logic [5:0] cmd_base = '0;
   logic [5:0] cmd_len = '0;
   logic       flush = 1'b0;
   logic [5:0] mem_addr;
   logic       mem_rd;
   logic [2:0] procc_instruction;
   logic       procc_start;
   logic       procc_done = 1'b0;
   logic       res_valid;
   logic [5:0] res_index;
   logic       cmd_done;
   logic       busy;
   logic [2:0] q_count;

   always #5 clk = ~clk;

   simd_issue_sched #(.QDEPTH(4), .AW(6), .OPW(3)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_opcode        (cmd_opcode),
      .cmd_base          (cmd_base),
      .cmd_len           (cmd_len),
      .flush             (flush),
      .mem_addr          (mem_addr),
      .mem_rd            (mem_rd),
      .procc_instruction (procc_instruction),
      .procc_start       (procc_start),
      .procc_done        (procc_done),
      .res_valid         (res_valid),
      .res_index         (res_index),
      .cmd_done          (cmd_done),
      .busy              (busy),
      .q_count           (q_count)
   );

   typedef struct {
      logic [2:0] op;
      logic [5:0] addr;
      logic [5:0] idx;
   } res_t;

   res_t exp_res[$];
   int   exp_len[$];

   int   n_vec = 0;
   int   n_err = 0;
   int   n_start = 0;
   int   n_res = 0;
   int   n_done = 0;
   int   cur_res = 0;
   logic stall = 1'b0;
   int   done_dly = 2;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Lane model: done arrives done_dly cycles after start, or later while stalled.
   initial begin
      forever begin
         @(negedge clk);
         procc_done = 1'b0;
         if (reset && procc_start) begin
            repeat (done_dly - 1) @(negedge clk);
            while (stall) @(negedge clk);
            procc_done = 1'b1;
         end
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         if (mem_rd) begin
            check("rd_expected", int'(exp_res.size() > 0), 1);
            if (exp_res.size() > 0) check("mem_addr", mem_addr, exp_res[0].addr);
         end
         if (procc_start) begin
            n_start++;
            check("start_expected", int'(exp_res.size() > 0), 1);
            if (exp_res.size() > 0) check("start_op", procc_instruction, exp_res[0].op);
         end
         if (res_valid) begin
            n_res++;
            cur_res++;
            check("res_expected", int'(exp_res.size() > 0), 1);
            if (exp_res.size() > 0) begin
               res_t e;
               e = exp_res.pop_front();
               check("res_index", res_index, e.idx);
               check("res_addr_hold", mem_addr, e.addr);
               check("res_op_hold", procc_instruction, e.op);
            end
         end
         if (cmd_done) begin
            n_done++;
            check("done_expected", int'(exp_len.size() > 0), 1);
            if (exp_len.size() > 0) check("cmd_vectors", cur_res, exp_len.pop_front());
            cur_res = 0;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the command was accepted.
   task automatic send(input logic [2:0] op, input logic [5:0] base, input logic [5:0] len);
      int t = 0;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_base   = base;
      cmd_len    = len;
      while (!cmd_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("send_accept", cmd_ready, 1);
      for (int i = 0; i < int'(len); i++) begin
         res_t e;
         e.op   = op;
         e.addr = base + 6'(i);
         e.idx  = 6'(i);
         exp_res.push_back(e);
      end
      exp_len.push_back(int'(len));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while ((busy || q_count != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("idle_reached", busy, 0);
   endtask

   // Returns at the negedge of the first WAIT cycle.
   task automatic wait_start();
      int t = 0;
      while (!procc_start && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("start_reached", procc_start, 1);
      @(negedge clk);
   endtask

   task automatic clear_sb();
      exp_res.delete();
      exp_len.delete();
      cur_res = 0;
   endtask

   int s0, r0, d0, t0;

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_q_count", q_count, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_instr", procc_instruction, 0);
      check("rst_start", procc_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_cmd_done", cmd_done, 0);
      reset = 1'b1;
      @(negedge clk);

      // Single command: addresses 5, 6
      s0 = n_start; r0 = n_res; d0 = n_done;
      send(3'd3, 6'd5, 6'd2);
      wait_idle();
      check("single_starts", n_start - s0, 2);
      check("single_results", n_res - r0, 2);
      check("single_done", n_done - d0, 1);

      // Address wrap: 62, 63, 0, 1
      done_dly = 4;
      send(3'd1, 6'd62, 6'd4);
      wait_idle();
      done_dly = 2;

      // Zero-length command
      s0 = n_start; r0 = n_res; d0 = n_done;
      send(3'd5, 6'd10, 6'd0);
      wait_idle();
      check("len0_starts", n_start - s0, 0);
      check("len0_results", n_res - r0, 0);
      check("len0_done", n_done - d0, 1);

      // Fill the queue behind a stalled command
      d0 = n_done;
      stall = 1'b1;
      send(3'd1, 6'd10, 6'd1);
      wait_start();
      fork
         begin
            send(3'd2, 6'd11, 6'd1);
            send(3'd3, 6'd12, 6'd2);
            send(3'd4, 6'd13, 6'd1);
            send(3'd5, 6'd14, 6'd1);
            send(3'd6, 6'd15, 6'd3);
         end
         begin
            t0 = 0;
            while (q_count != 3'd4 && t0 < 50) begin
               @(negedge clk);
               t0++;
            end
            check("full_q_count", q_count, 4);
            check("full_cmd_ready", cmd_ready, 0);
            repeat (3) @(negedge clk);
            check("full_held_count", q_count, 4);
            check("full_held_ready", cmd_ready, 0);
            stall = 1'b0;
         end
      join
      wait_idle();
      check("full_all_done", n_done - d0, 6);

      // Flush in WAIT with two queued; a push offered in the flush cycle is dropped
      stall = 1'b1;
      send(3'd7, 6'd40, 6'd2);
      wait_start();
      send(3'd1, 6'd0, 6'd1);
      send(3'd2, 6'd1, 6'd1);
      check("flush_pre_count", q_count, 2);
      r0 = n_res; d0 = n_done;
      cmd_valid = 1'b1; cmd_opcode = 3'd5; cmd_base = 6'd9; cmd_len = 6'd1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      cmd_valid = 1'b0;
      clear_sb();
      check("flush_busy", busy, 0);
      check("flush_q_count", q_count, 0);
      check("flush_cmd_ready", cmd_ready, 1);
      stall = 1'b0;
      repeat (6) @(negedge clk);
      check("flush_late_busy", busy, 0);
      check("flush_no_result", n_res - r0, 0);
      check("flush_no_done", n_done - d0, 0);

      // Reset while in NEXT, then a fresh command
      send(3'd4, 6'd20, 6'd3);
      t0 = 0;
      while (!res_valid && t0 < 200) begin
         @(negedge clk);
         t0++;
      end
      check("rstnext_reached", res_valid, 1);
      #1 reset = 1'b0;
      #1;
      check("rstnext_busy", busy, 0);
      check("rstnext_res_valid", res_valid, 0);
      check("rstnext_res_index", res_index, 0);
      check("rstnext_mem_addr", mem_addr, 0);
      check("rstnext_instr", procc_instruction, 0);
      check("rstnext_q_count", q_count, 0);
      check("rstnext_cmd_ready", cmd_ready, 1);
      check("rstnext_cmd_done", cmd_done, 0);
      clear_sb();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      d0 = n_done; r0 = n_res;
      send(3'd6, 6'd30, 6'd2);
      wait_idle();
      check("rstnext_new_results", n_res - r0, 2);
      check("rstnext_new_done", n_done - d0, 1);
      check("sb_res_drained", exp_res.size(), 0);
      check("sb_len_drained", exp_len.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
